// File: rtl/core_run_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// core_run_ctrl
//   Run controller for the pipelined RV core. It holds the core in reset for
//   RST_CYCLES cycles after a start pulse, lets it run, and watches the
//   data-memory write port for a store to TOHOST_ADDR, which ends the run.
//   A watchdog ends the run after MAX_CYCLES run cycles (0 disables it).
//   Status (done/pass/timeout/exit_code) and the run-cycle count are held
//   until the next start.
//
// Optional feature macro: RUN_CTRL_STORE_CNT_EN
//   When defined, adds store_cnt, a saturating count of dmem_we cycles seen
//   during RUN (including the halting store).
//
// Ports
//   clk         in   1       system clock, rising edge
//   rst         in   1       asynchronous active-high reset
//   start       in   1       start pulse, accepted in IDLE or DONE
//   dmem_we     in   1       core data-memory write enable
//   dmem_addr   in   ADDR_W  core data-memory address
//   dmem_wdata  in   DATA_W  core data-memory write data
//   core_rst    out  1       reset to top_core, active-high
//   running     out  1       high while the core runs
//   done        out  1       sticky run-complete flag
//   pass        out  1       run ended with exit code 1
//   timeout     out  1       run ended by the watchdog
//   exit_code   out  DATA_W  data of the halting store
//   cycle_cnt   out  CNT_W   run cycles elapsed, saturating
//   dbg_state   out  2       current FSM state (IDLE=0 RESET=1 RUN=2 DONE=3)
//   store_cnt   out  CNT_W   stores seen in RUN (RUN_CTRL_STORE_CNT_EN only)
//
// Handshake: start has no ready. A start that is high on a rising edge while
// the FSM is in IDLE or DONE begins a run; in RESET or RUN it is dropped.
// -----------------------------------------------------------------------------
module core_run_ctrl #(
  parameter int                RST_CYCLES  = 5,
  parameter int                MAX_CYCLES  = 50,
  parameter int                CNT_W       = 32,
  parameter int                ADDR_W      = 32,
  parameter int                DATA_W      = 32,
  parameter logic [ADDR_W-1:0] TOHOST_ADDR = 32'h0000_1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              dmem_we,
  input  logic [ADDR_W-1:0] dmem_addr,
  input  logic [DATA_W-1:0] dmem_wdata,
  output logic              core_rst,
  output logic              running,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic [DATA_W-1:0] exit_code,
  output logic [CNT_W-1:0]  cycle_cnt,
  output logic [1:0]        dbg_state
`ifdef RUN_CTRL_STORE_CNT_EN
  ,
  output logic [CNT_W-1:0]  store_cnt
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RESET = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Watchdog fires while the last budgeted cycle is in progress, so the
  // count reads exactly MAX_CYCLES once DONE is reached.
  localparam logic [CNT_W-1:0] LAST_CYC = CNT_W'(MAX_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] rst_cnt_q;
  logic             halt, expire, launch;

  assign halt      = dmem_we && (dmem_addr == TOHOST_ADDR);
  assign expire    = (MAX_CYCLES != 0) && (cycle_cnt == LAST_CYC);
  assign launch    = start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign dbg_state = state_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RESET;
      // rst_cnt_q is loaded with RST_CYCLES on entry, so leaving when it
      // reads 1 gives exactly RST_CYCLES cycles in RESET.
      S_RESET: if (rst_cnt_q <= CNT_W'(1)) state_d = S_RUN;
      S_RUN:   if (halt || expire) state_d = S_DONE;
      S_DONE:  if (start) state_d = S_RESET;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      rst_cnt_q <= '0;
      core_rst  <= 1'b1;
      running   <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      timeout   <= 1'b0;
      exit_code <= '0;
      cycle_cnt <= '0;
    end else begin
      state_q  <= state_d;
      // Outputs are registered from the next state so they line up with it.
      core_rst <= (state_d != S_RUN);
      running  <= (state_d == S_RUN);
      if (launch) begin
        rst_cnt_q <= CNT_W'(RST_CYCLES);
        done      <= 1'b0;
        pass      <= 1'b0;
        timeout   <= 1'b0;
        exit_code <= '0;
        cycle_cnt <= '0;
      end else if (state_q == S_RESET) begin
        rst_cnt_q <= rst_cnt_q - CNT_W'(1);
      end else if (state_q == S_RUN) begin
        if (cycle_cnt != '1) cycle_cnt <= cycle_cnt + CNT_W'(1);
        if (halt) begin
          // A halt in the last budgeted cycle still counts as a clean exit.
          done      <= 1'b1;
          exit_code <= dmem_wdata;
          pass      <= (dmem_wdata == DATA_W'(1));
        end else if (expire) begin
          done    <= 1'b1;
          timeout <= 1'b1;
        end
      end
    end
  end

`ifdef RUN_CTRL_STORE_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      store_cnt <= '0;
    end else if (launch) begin
      store_cnt <= '0;
    end else if ((state_q == S_RUN) && dmem_we && (store_cnt != '1)) begin
      store_cnt <= store_cnt + CNT_W'(1);
    end
  end
`else
  // No store counter in this build.
`endif

endmodule
